// File: rtl/ntt_mem_pkg.sv
// ntt_mem_pkg: shared widths and helpers for the NTT host-memory arbiter
package ntt_mem_pkg;
  localparam int ADDR_W_DEF = 48;
  localparam int DATA_W_DEF = 64;
  function automatic int tag_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
  function automatic int rr_next(input int k, input int n);
    return (k + 1) % n;
  endfunction
endpackage

// File: rtl/ntt_mem_arbiter_tag_fifo.sv
// arb_tag_fifo: synchronous FIFO of issuing core IDs for in-order read responses
module arb_tag_fifo #(
  parameter int DEPTH = 8,
  parameter int W = 2,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic wr, rd;
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign wr = push & !full;
  assign rd = pop & !empty;
  assign dout = mem[rp];
  always_ff @(posedge clk) if (wr) mem[wp] <= din;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      wp <= wp + AW'(wr);
      rp <= rp + AW'(rd);
      count <= count + (AW+1)'(wr) - (AW+1)'(rd);
    end
endmodule

// File: rtl/ntt_mem_arbiter.sv
// ntt_mem_arbiter: round-robin share of one host-memory port among NTT engines.
// Define NTT_ARB_PERF_EN to add saturating grant/conflict performance counters.
module ntt_mem_arbiter
  import ntt_mem_pkg::*;
#(
  parameter int NUM_CORES = 4,
  parameter int MAX_OUTSTANDING = 8,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  localparam int OW = $clog2(MAX_OUTSTANDING) + 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_CORES-1:0]          core_req,
  input  logic [NUM_CORES-1:0]          core_we,
  input  logic [NUM_CORES*ADDR_W-1:0]   core_addr,
  input  logic [NUM_CORES*DATA_W-1:0]   core_wdata,
  output logic [NUM_CORES-1:0]          core_gnt,
  output logic [NUM_CORES-1:0]          core_valid,
  output logic [DATA_W-1:0]             core_rdata,
  output logic                          mem_req_valid,
  input  logic                          mem_req_ready,
  output logic                          mem_we,
  output logic [ADDR_W-1:0]             mem_addr,
  output logic [DATA_W-1:0]             mem_wdata,
  input  logic                          mem_rsp_valid,
  input  logic [DATA_W-1:0]             mem_rsp_data,
  output logic [OW-1:0]                 outstanding,
  output logic                          err_orphan
`ifdef NTT_ARB_PERF_EN
  ,
  output logic [NUM_CORES*32-1:0]       perf_grants,
  output logic [31:0]                   perf_conflicts
`endif
);
  localparam int TW = tag_w(NUM_CORES);
  logic [NUM_CORES-1:0] req, elig;
  logic [TW-1:0] rr_ptr, sel, tag;
  logic full, empty, found, grant, push, pop;
  assign req = rst ? '0 : core_req;
  assign elig = req & (core_we | {NUM_CORES{!full}});
  always_comb begin
    sel = '0;
    found = 1'b0;
    for (int o = 0; o < NUM_CORES; o++)
      if (!found && elig[(int'(rr_ptr) + o) % NUM_CORES]) begin
        found = 1'b1;
        sel = TW'((int'(rr_ptr) + o) % NUM_CORES);
      end
  end
  assign mem_req_valid = |elig;
  assign grant = mem_req_valid & mem_req_ready;
  assign mem_we = mem_req_valid & core_we[sel];
  assign mem_addr = mem_req_valid ? core_addr[sel*ADDR_W +: ADDR_W] : '0;
  assign mem_wdata = mem_req_valid ? core_wdata[sel*DATA_W +: DATA_W] : '0;
  assign core_gnt = grant ? NUM_CORES'(1) << sel : '0;
  assign push = grant & !core_we[sel];
  assign pop = mem_rsp_valid & !empty;
  arb_tag_fifo #(.DEPTH(MAX_OUTSTANDING), .W(TW)) u_tags (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .din(sel), .dout(tag),
    .full(full), .empty(empty), .count(outstanding)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rr_ptr <= '0;
      core_valid <= '0;
      core_rdata <= '0;
      err_orphan <= 1'b0;
    end else begin
      if (grant) rr_ptr <= TW'(rr_next(int'(sel), NUM_CORES));
      core_valid <= pop ? NUM_CORES'(1) << tag : '0;
      if (pop) core_rdata <= mem_rsp_data;
      err_orphan <= err_orphan | (mem_rsp_valid & empty);
    end
`ifdef NTT_ARB_PERF_EN
  for (genvar i = 0; i < NUM_CORES; i++) begin : g_perf
    always_ff @(posedge clk or posedge rst)
      if (rst) perf_grants[i*32 +: 32] <= '0;
      else if (core_gnt[i] && !(&perf_grants[i*32 +: 32])) perf_grants[i*32 +: 32] <= perf_grants[i*32 +: 32] + 32'd1;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) perf_conflicts <= '0;
    else if (($countones(elig) >= 2 || (mem_req_valid && !mem_req_ready)) && !(&perf_conflicts))
      perf_conflicts <= perf_conflicts + 32'd1;
`endif
endmodule

// File: tb/tb_ntt_mem_arbiter.sv
// tb_ntt_mem_arbiter: randomized and directed checks against a queue-based arbiter model
module tb_ntt_mem_arbiter;
  localparam int N = 4, MO = 8, AW = 48, DW = 64;
  logic clk = 1'b0, rst;
  logic [N-1:0] req, we, core_gnt, core_valid;
  logic [AW-1:0] addr [N];
  logic [DW-1:0] wd [N];
  logic [N*AW-1:0] core_addr;
  logic [N*DW-1:0] core_wdata;
  logic [DW-1:0] core_rdata, mem_wdata, rsp_d;
  logic mem_req_valid, ready, mem_we, rsp_v, err_orphan;
  logic [AW-1:0] mem_addr;
  logic [$clog2(MO):0] outstanding;
`ifdef NTT_ARB_PERF_EN
  logic [N*32-1:0] perf_grants;
  logic [31:0] perf_conflicts;
`endif
  int rr, checks, passes;
  int q[$];
  bit orph;
  logic [N-1:0] ev;
  logic [DW-1:0] ed;
  int obs[N];
  always #5 clk = ~clk;
  always_comb begin
    core_addr = '0;
    core_wdata = '0;
    for (int i = 0; i < N; i++) begin
      core_addr[i*AW +: AW] = addr[i];
      core_wdata[i*DW +: DW] = wd[i];
    end
  end
  ntt_mem_arbiter #(.NUM_CORES(N), .MAX_OUTSTANDING(MO), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .core_req(req), .core_we(we), .core_addr(core_addr),
    .core_wdata(core_wdata), .core_gnt(core_gnt), .core_valid(core_valid),
    .core_rdata(core_rdata), .mem_req_valid(mem_req_valid), .mem_req_ready(ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rsp_valid(rsp_v), .mem_rsp_data(rsp_d), .outstanding(outstanding),
    .err_orphan(err_orphan)
`ifdef NTT_ARB_PERF_EN
    , .perf_grants(perf_grants), .perf_conflicts(perf_conflicts)
`endif
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask
  task automatic cycle();
    int s = -1;
    bit v;
    for (int o = 0; o < N; o++) begin
      int i = (rr + o) % N;
      if (s < 0 && req[i] && (we[i] || q.size() < MO)) s = i;
    end
    v = s >= 0;
    if (!v) s = 0;
    @(negedge clk);
    check("req_valid", 64'(mem_req_valid), 64'(v));
    check("gnt", 64'(core_gnt), (v && ready) ? 64'(1) << s : 64'd0);
    check("mem_we", 64'(mem_we), v ? 64'(we[s]) : 64'd0);
    check("mem_addr", 64'(mem_addr), v ? 64'(addr[s]) : 64'd0);
    check("mem_wdata", mem_wdata, v ? wd[s] : 64'd0);
    check("outstanding", 64'(outstanding), 64'(q.size()));
    check("core_valid", 64'(core_valid), 64'(ev));
    check("core_rdata", core_rdata, ed);
    check("err_orphan", 64'(err_orphan), 64'(orph));
    for (int i = 0; i < N; i++) if (core_gnt[i]) obs[i]++;
    @(posedge clk);
    ev = '0;
    if (rsp_v) begin
      if (q.size() > 0) begin
        ev = N'(1) << q.pop_front();
        ed = rsp_d;
      end else orph = 1'b1;
    end
    if (v && ready) begin
      rr = (s + 1) % N;
      if (!we[s]) q.push_back(s);
    end
    #1;
  endtask
  task automatic idle_inputs();
    req = '0; we = '0; ready = 1'b1; rsp_v = 1'b0; rsp_d = '0;
  endtask
  task automatic model_reset();
    q.delete(); rr = 0; orph = 1'b0; ev = '0; ed = '0;
  endtask
  task automatic drain();
    req = '0;
    rsp_v = 1'b1;
    for (int k = 0; k < 2*MO && q.size() > 0; k++) begin
      rsp_d = {$urandom, $urandom};
      cycle();
    end
    rsp_v = 1'b0;
    cycle();
  endtask
  initial begin
    checks = 0; passes = 0;
    for (int i = 0; i < N; i++) begin
      addr[i] = AW'(48'h100 * (i + 1));
      wd[i] = 64'hA0 + 64'(i);
    end
    idle_inputs();
    req = '1;
    rst = 1'b1;
    model_reset();
    #2;
    check("rst_gnt", 64'(core_gnt), 64'd0);
    check("rst_valid", 64'(mem_req_valid), 64'd0);
    check("rst_outst", 64'(outstanding), 64'd0);
    check("rst_orphan", 64'(err_orphan), 64'd0);
    check("rst_cvalid", 64'(core_valid), 64'd0);
    check("rst_rdata", core_rdata, 64'd0);
    idle_inputs();
    @(negedge clk) rst = 1'b0;
    @(posedge clk) #1;
    // single read from core1, response three cycles later
    req = 4'b0010; addr[1] = 48'h1000;
    cycle();
    req = '0;
    cycle(); cycle();
    rsp_v = 1'b1; rsp_d = 64'hDEAD;
    cycle();
    rsp_v = 1'b0;
    cycle();
    check("sr_rdata", core_rdata, 64'hDEAD);
    // fairness across four writers
    for (int i = 0; i < N; i++) obs[i] = 0;
    req = '1; we = '1;
    repeat (100) cycle();
    for (int i = 0; i < N; i++) check($sformatf("fair%0d", i), 64'(obs[i]), 64'd25);
    // backpressure with stable address
    req = 4'b0100; we = '0; ready = 1'b0; addr[2] = 48'hBEEF_0000;
    repeat (5) cycle();
    ready = 1'b1;
    cycle();
    req = '0;
    drain();
    // fill the tag FIFO, then a competing write and read
    req = 4'b0001; we = '0;
    repeat (MO) cycle();
    check("full_outst", 64'(outstanding), 64'(MO));
    req = 4'b1001; we = 4'b1000;
    cycle();
    req = 4'b0001; we = '0; rsp_v = 1'b1; rsp_d = 64'h1234;
    cycle();
    rsp_v = 1'b0;
    cycle();
    req = '0;
    drain();
    // interleaved reads with a push and pop in the same cycle
    we = '0;
    req = 4'b0001; cycle();
    req = 4'b0100; cycle();
    req = 4'b0010; cycle();
    req = 4'b1000; rsp_v = 1'b1; rsp_d = 64'hA; cycle();
    req = '0; rsp_d = 64'hB; cycle();
    rsp_d = 64'hC; cycle();
    drain();
    // randomized traffic
    for (int k = 0; k < 400; k++) begin
      req = N'($urandom); we = N'($urandom);
      ready = $urandom_range(0, 3) != 0;
      rsp_v = q.size() > 0 && $urandom_range(0, 2) == 0;
      rsp_d = {$urandom, $urandom};
      for (int i = 0; i < N; i++) begin
        addr[i] = AW'({$urandom, $urandom});
        wd[i] = {$urandom, $urandom};
      end
      cycle();
    end
    ready = 1'b1;
    drain();
    // orphan response, then asynchronous reset mid-burst
    rsp_v = 1'b1; rsp_d = 64'hBAD;
    cycle();
    rsp_v = 1'b0;
    cycle();
    req = '1; we = '0;
    repeat (3) cycle();
    #2 rst = 1'b1;
    model_reset();
    #1;
    check("arst_outst", 64'(outstanding), 64'd0);
    check("arst_orphan", 64'(err_orphan), 64'd0);
    check("arst_gnt", 64'(core_gnt), 64'd0);
    check("arst_valid", 64'(mem_req_valid), 64'd0);
    @(negedge clk) rst = 1'b0;
    req = '0;
    @(posedge clk) #1;
    req = '1; we = '1;
    repeat (4) cycle();
    req = '0;
    rsp_v = 1'b1; cycle();
    rsp_v = 1'b0; cycle();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/ntt_mem_arbiter.md
Name: ntt_mem_arbiter

Overview:
- Shares one host-memory port among NUM_CORES ntt_engine instances.
- Each engine drives its req/we/addr/wdata/gnt/valid/rdata DMA interface into this block; the block drives a single valid/ready request channel toward the memory system.
- Round-robin grant; zero-cycle grant when memory is ready.
- Read responses return in order and are routed to their issuing core through a tag FIFO of core IDs.

Parameters:
- NUM_CORES, 4, number of engine requesters (2..8).
- MAX_OUTSTANDING, 8, maximum in-flight reads; tag FIFO depth (power of 2).
- ADDR_W, 48, address width.
- DATA_W, 64, data width.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- core_req  in  NUM_CORES  per-core request, level.
- core_we  in  NUM_CORES  per-core write enable.
- core_addr  in  NUM_CORES*ADDR_W  per-core byte address; core i occupies slice i.
- core_wdata  in  NUM_CORES*DATA_W  per-core write data, slice i.
- core_gnt  out  NUM_CORES  one-hot acceptance pulse, combinational.
- core_valid  out  NUM_CORES  one-hot read-response strobe, registered.
- core_rdata  out  DATA_W  read data broadcast to all cores, registered.
- mem_req_valid  out  1  request to memory.
- mem_req_ready  in  1  memory accepts request.
- mem_we  out  1  write flag of the forwarded request.
- mem_addr  out  ADDR_W  address of the forwarded request.
- mem_wdata  out  DATA_W  write data of the forwarded request.
- mem_rsp_valid  in  1  read response, in request order.
- mem_rsp_data  in  DATA_W  read response data.
- outstanding  out  $clog2(MAX_OUTSTANDING)+1  current in-flight read count.
- err_orphan  out  1  sticky: response arrived with an empty tag FIFO.

Behaviour:
- Reset values: core_valid=0, core_rdata=0, rr_ptr=0, tag FIFO empty, outstanding=0, err_orphan=0. core_gnt and mem_req_valid are 0 because every core_req is ignored while rst is high.
- Eligibility: core i is eligible if core_req[i]=1 and (core_we[i]=1 or tag FIFO not full). Writes never consume FIFO entries.
- Selection: first eligible core scanning rr_ptr, rr_ptr+1, … mod NUM_CORES. The selection is combinational.
- mem_req_valid = any eligible core. mem_we/addr/wdata are muxed from the selected core; they are 0 when nothing is selected.
- Grant: core_gnt[sel] = mem_req_valid & mem_req_ready, in the same cycle (zero-latency handshake).
- Pointer: on a grant to core k, rr_ptr <= (k+1) mod NUM_CORES at the clock edge. Without a grant it holds.
- Read grant: push sel into the tag FIFO at the same edge.
- Response: on mem_rsp_valid with FIFO non-empty, pop the head tag. Next cycle: core_valid[tag]=1 and core_rdata=mem_rsp_data. Response latency is 1 cycle. Otherwise core_valid=0 and core_rdata holds its last value.
- Simultaneous push and pop: both occur; count is unchanged; full is evaluated on the pre-edge count.
- Full FIFO: read requests are not eligible; write requests from other cores continue to be granted.
- Orphan: mem_rsp_valid with an empty FIFO drops the data, keeps core_valid=0, and sets err_orphan=1 until reset.
- Engine compatibility: a core holding core_req across cycles receives one gnt per accepted beat, so back-to-back write bursts are legal. A core that drops req after gnt loses nothing.
- Reset mid-operation: FIFO is flushed and the pointer cleared. Memory responses still in flight afterward are treated as orphans and set err_orphan. The system resets memory alongside this block.

Optional Feature:
- Macro: NTT_ARB_PERF_EN.
- Defined: adds outputs perf_grants (NUM_CORES*32, per-core accepted-request counters) and perf_conflicts (32, cycles with at least two eligible cores or with mem_req_valid & !mem_req_ready). Counters saturate at all-ones and reset to 0.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Package ntt_mem_pkg: ADDR_W/DATA_W defaults, the core-ID tag width function ($clog2 wrapper), and the round-robin next-pointer function.
- Sub-module arb_tag_fifo: synchronous FIFO of core IDs. Ports: push, pop, din, dout, full, empty, count. Async reset.

Test Plan:
- Single read: core1 issues a read to 0x1000; memory ready, response 0xDEAD three cycles later -> core_gnt=0b0010 in the request cycle, core_valid=0b0010 and core_rdata=0xDEAD one cycle after mem_rsp_valid, outstanding returns to 0.
- Fairness: all 4 cores hold req continuously with writes, mem_req_ready=1 -> grant order 0,1,2,3,0,1,…; each core receives exactly 25 of 100 grants.
- Backpressure: mem_req_ready=0 for 5 cycles with core2 requesting -> no gnt and mem_req_valid=1 with stable addr; the grant occurs in the first ready cycle.
- Full FIFO: 8 reads outstanding with no responses, then core0 reads and core3 writes -> only core3 is granted. After one response, core0 is granted at the next edge.
- Interleaved reads: cores 0,2,1 read in that order; responses A,B,C -> core_valid pulses 0b0001(A), 0b0100(B), 0b0010(C). A push and pop in the same cycle leaves outstanding unchanged.
- Orphan and reset: pulse mem_rsp_valid with an empty FIFO -> err_orphan=1 and no core_valid. Asserting rst asynchronously mid-burst clears FIFO, rr_ptr and err_orphan immediately.
